data_mem: RTL and testbench

Word-organised data memory with byte/halfword/word access, sitting directly downstream of the ALU in the single-cycle datapath. The ALU result is the effective address; store data comes from the register file, and load data goes to the write-back mux. The block performs little-endian lane selection, sign/zero extension, alignment and range checking, and keeps a sticky fault record for debug.

---
 rtl/data_mem.sv | 109 ++++++++++
 tb/tb_data_mem.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// rtl/data_mem.sv - byte/half/word data memory with lane select, extension, range/alignment checks and sticky fault
module data_mem #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic        fault_clr,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        out_of_range,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   addr_hi;
  logic          access;
  logic          bad;
  logic          wr_en;
  logic          rd_en;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   word;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;

  assign idx     = addr[AW+1:2];
  assign addr_hi = addr >> (AW + 2);
  assign access  = mem_read | mem_write;
  assign bad     = misaligned | out_of_range;
  assign wr_en   = mem_write & ~bad;
  assign rd_en   = mem_read & ~bad;
  assign word    = mem[idx];

  // Address checks: any bit above the array span is out of range; size 11 behaves as word.
  always_comb begin
    out_of_range = |addr_hi;
    misaligned   = ((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00));
  end

  // Store lane enables and lane-replicated data so each lane picks its own byte.
  always_comb begin
    be = 4'b1111;
    wd = wdata;
    case (size)
      2'b00: begin
        be = 4'b0001 << addr[1:0];
        wd = {4{wdata[7:0]}};
      end
      2'b01: begin
        be = addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata;
      end
    endcase
  end

  // Load path: little-endian lane select then sign/zero extension; zero when not a valid load.
  always_comb begin
    rbyte = word[8*addr[1:0] +: 8];
    rhalf = addr[1] ? word[31:16] : word[15:0];
    rdata = 32'h0;
    if (rd_en) begin
      case (size)
        2'b00:   rdata = {{24{~unsigned_ld & rbyte[7]}}, rbyte};
        2'b01:   rdata = {{16{~unsigned_ld & rhalf[15]}}, rhalf};
        default: rdata = word;
      endcase
    end
  end

  // Storage array: cleared on reset, otherwise only enabled lanes of the addressed word update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  // Sticky fault: first fault is kept; a fault arriving with fault_clr replaces the record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault      <= 1'b0;
      fault_addr <= 32'h0;
    end else if (access && bad && (!fault || fault_clr)) begin
      fault      <= 1'b1;
      fault_addr <= addr;
    end else if (fault_clr) begin
      fault      <= 1'b0;
      fault_addr <= 32'h0;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - scoreboard bench for data_mem against a byte-array reference model
module tb_data_mem;

  localparam int DEPTH = 256;
  localparam int NBYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic        fault_clr;
  logic [31:0] rdata;
  logic        misaligned;
  logic        out_of_range;
  logic        fault;
  logic [31:0] fault_addr;

  data_mem #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write), .size(size),
    .unsigned_ld(unsigned_ld), .fault_clr(fault_clr), .rdata(rdata),
    .misaligned(misaligned), .out_of_range(out_of_range),
    .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        oor;
    logic        fault;
    logic [31:0] fa;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mb [NBYTES];
  logic        m_fault;
  logic [31:0] m_fa;
  bit          done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h0;
    m_fault = 1'b0;
    m_fa    = 32'h0;
  endfunction

  // One cycle: drive, predict from the byte-level model, push, then advance model across the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr,
                      input logic [1:0] sz, input bit uns, input bit clr, input bit drop_rst);
    exp_t e;
    int   n;
    bit   mis, oor, nf;
    logic [31:0] v;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    addr = a; wdata = d; mem_read = rd; mem_write = wr;
    size = sz; unsigned_ld = uns; fault_clr = clr;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = (a % n) != 0;
    oor = {32'h0, a} >= 64'(NBYTES);
    if (drop_rst) begin
      #1;
      rst_n = 1'b0;
      model_reset();
    end
    v = 32'h0;
    if (rd && !mis && !oor) begin
      for (int i = 0; i < n; i++) v = v | (32'(mb[a + i]) << (8 * i));
      if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    end
    e.rdata = v; e.mis = mis; e.oor = oor; e.fault = m_fault; e.fa = m_fa;
    sb.push_back(e);
    if (!drop_rst) begin
      if (wr && !mis && !oor)
        for (int i = 0; i < n; i++) mb[a + i] = 8'((d >> (8 * i)) & 32'hFF);
      nf = (rd || wr) && (mis || oor);
      if (nf && (!m_fault || clr)) begin
        m_fault = 1'b1; m_fa = a;
      end else if (clr) begin
        m_fault = 1'b0; m_fa = 32'h0;
      end
    end
  endtask

  // Monitor: every cycle the DUT presents a result; compare it against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rdata", rdata, e.rdata);
        chk("misaligned", 32'(misaligned), 32'(e.mis));
        chk("out_of_range", 32'(out_of_range), 32'(e.oor));
        chk("fault", 32'(fault), 32'(e.fault));
        chk("fault_addr", fault_addr, e.fa);
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;
    rst_n = 1'b0; addr = 0; wdata = 0; mem_read = 0; mem_write = 0;
    size = 0; unsigned_ld = 0; fault_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);

    step(32'h0, 0, 1, 0, 2'd2, 0, 0, 0);
    step(32'h10, 32'hDEADBEEF, 0, 1, 2'd2, 0, 0, 0);
    step(32'h10, 0, 1, 0, 2'd2, 0, 0, 0);
    step(32'h13, 0, 1, 0, 2'd0, 0, 0, 0);
    step(32'h10, 0, 1, 0, 2'd0, 1, 0, 0);

    step(32'h0, 32'h0, 0, 1, 2'd2, 0, 0, 0);
    step(32'h2, 32'hAB, 0, 1, 2'd0, 0, 0, 0);
    step(32'h0, 32'h8001, 0, 1, 2'd1, 0, 0, 0);
    step(32'h0, 0, 1, 0, 2'd2, 0, 0, 0);
    step(32'h0, 0, 1, 0, 2'd1, 0, 0, 0);
    step(32'h0, 0, 1, 0, 2'd1, 1, 0, 0);

    step(32'h4, 32'h11223344, 0, 1, 2'd2, 0, 0, 0);
    step(32'h5, 32'hFFFF, 0, 1, 2'd1, 0, 0, 0);
    step(32'h4, 0, 1, 0, 2'd2, 0, 0, 0);
    step(32'h6, 0, 1, 0, 2'd2, 0, 0, 0);
    step(32'h0, 0, 0, 0, 2'd0, 0, 0, 0);

    step(32'h400, 32'h55, 0, 1, 2'd2, 0, 1, 0);
    step(32'h0, 0, 1, 0, 2'd2, 0, 0, 0);
    step(32'h0, 0, 0, 0, 2'd0, 0, 1, 0);
    step(32'h0, 0, 0, 0, 2'd0, 0, 0, 0);

    step(32'h20, 32'hCAFEF00D, 0, 1, 2'd2, 0, 0, 0);
    step(32'h3, 0, 1, 0, 2'd2, 0, 0, 0);
    step(32'h24, 32'h12345678, 0, 1, 2'd2, 0, 0, 1);
    step(32'h20, 0, 1, 0, 2'd2, 0, 0, 0);
    step(32'h24, 0, 1, 0, 2'd2, 0, 0, 0);

    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      a = $urandom_range(0, 63);
      else if (r < 85) a = $urandom_range(32'h3F0, 32'h40F);
      else             a = $urandom;
      sz = 2'($urandom_range(0, 3));
      step(a, $urandom, 1'($urandom), 1'($urandom), sz, 1'($urandom),
           ($urandom_range(0, 9) == 0), 1'b0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
